// File: rtl/dcc_pkg.sv
// Shared definitions for the delta-colour-compression encoder and block writer.
package dcc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    META = 2'd2
  } dcc_state_e;

  // Beats for a compressed block: one base beat plus the packed delta beats.
  function automatic int calc_nc(input int delta_bits, input int beat_bits);
    return 1 + (64 * delta_bits) / beat_bits;
  endfunction

  function automatic int calc_nr(input int block_pixels, input int pixel_bits,
                                 input int beat_bits);
    return (block_pixels * pixel_bits) / beat_bits;
  endfunction

  localparam int NC = calc_nc(4, 32);
  localparam int NR = calc_nr(16, 32, 32);

  function automatic bit delta_bits_legal(input int delta_bits);
    return (delta_bits == 2) || (delta_bits == 4) || (delta_bits == 8);
  endfunction

endpackage

// File: rtl/dcc_sat_counter.sv
// Saturating event counter: counts up on i_inc, sticks at all-ones.
module dcc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dcc_block_writer.sv
// Serializes one encoded 4x4 block into memory write beats, then one metadata
// write, and keeps saturating completion statistics.
module dcc_block_writer
  import dcc_pkg::*;
#(
  parameter int BLOCK_PIXELS = 16,
  parameter int PIXEL_BITS   = 32,
  parameter int DELTA_BITS   = 4,
  parameter int BEAT_BITS    = 32,
  parameter int BLK_IDX_BITS = 16,
  parameter int STAT_BITS    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               blk_valid,
  output logic                               blk_ready,
  input  logic [BLK_IDX_BITS-1:0]            blk_idx,
  input  logic                               blk_compressible,
  input  logic [PIXEL_BITS-1:0]              blk_base,
  input  logic [64*DELTA_BITS-1:0]           blk_deltas,
  input  logic [BLOCK_PIXELS*PIXEL_BITS-1:0] blk_pixels,
  output logic                               mem_valid,
  input  logic                               mem_ready,
  output logic [BLK_IDX_BITS+3:0]            mem_addr,
  output logic [BEAT_BITS-1:0]               mem_data,
  output logic                               mem_last,
  output logic                               meta_valid,
  input  logic                               meta_ready,
  output logic [BLK_IDX_BITS-1:0]            meta_idx,
  output logic                               meta_comp,
  output logic [STAT_BITS-1:0]               stat_blocks,
  output logic [STAT_BITS-1:0]               stat_comp
);

  localparam int N_COMP   = calc_nc(DELTA_BITS, BEAT_BITS);
  localparam int N_RAW    = calc_nr(BLOCK_PIXELS, PIXEL_BITS, BEAT_BITS);
  localparam int N_DWORDS = N_COMP - 1;
  localparam logic [3:0] LAST_COMP = 4'(N_COMP - 1);
  localparam logic [3:0] LAST_RAW  = 4'(N_RAW - 1);

  if (!delta_bits_legal(DELTA_BITS)) begin : g_bad_delta_bits
    $error("dcc_block_writer: DELTA_BITS must be 2, 4 or 8");
  end
  if (((64 * DELTA_BITS) % BEAT_BITS) != 0) begin : g_bad_delta_pack
    $error("dcc_block_writer: delta field is not a whole number of beats");
  end
  if (PIXEL_BITS != BEAT_BITS) begin : g_bad_beat_width
    $error("dcc_block_writer: PIXEL_BITS must equal BEAT_BITS");
  end
  if ((N_RAW > 16) || (N_COMP > 16)) begin : g_bad_slot
    $error("dcc_block_writer: a block must fit its 16-beat address slot");
  end

  dcc_state_e                        r_state;
  logic [3:0]                        r_beat;
  logic [BLK_IDX_BITS-1:0]           r_idx;
  logic                              r_comp;
  logic [PIXEL_BITS-1:0]             r_base;
  logic [64*DELTA_BITS-1:0]          r_deltas;
  logic [BLOCK_PIXELS*PIXEL_BITS-1:0] r_pixels;

  logic                 w_accept;
  logic                 w_is_last;
  logic                 w_meta_done;
  logic [BEAT_BITS-1:0] w_data;
  logic [BEAT_BITS-1:0] w_dwords [16];
  logic [BEAT_BITS-1:0] w_pwords [16];

  assign w_accept    = (r_state == IDLE) && blk_valid;
  assign w_is_last   = (r_beat == (r_comp ? LAST_COMP : LAST_RAW));
  assign w_meta_done = (r_state == META) && meta_ready;

  for (genvar k = 0; k < 16; k++) begin : g_words
    if (k < N_DWORDS) begin : g_dw
      assign w_dwords[k] = r_deltas[k*BEAT_BITS +: BEAT_BITS];
    end else begin : g_dw_pad
      assign w_dwords[k] = '0;
    end
    if (k < N_RAW) begin : g_pw
      assign w_pwords[k] = r_pixels[k*BEAT_BITS +: BEAT_BITS];
    end else begin : g_pw_pad
      assign w_pwords[k] = '0;
    end
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    w_data = '0;
    if (r_state == DATA) begin
      if (r_comp) begin
        w_data = (r_beat == 4'd0) ? r_base : w_dwords[r_beat - 4'd1];
      end else begin
        w_data = w_pwords[r_beat];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_idx   <= '0;
      r_comp  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (blk_valid) begin
            r_idx   <= blk_idx;
            r_comp  <= blk_compressible;
            r_beat  <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (mem_ready) begin
            if (w_is_last) r_state <= META;
            else           r_beat  <= r_beat + 4'd1;
          end
        end
        META: begin
          if (meta_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while the FSM is in DATA.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_base   <= blk_base;
      r_deltas <= blk_deltas;
      r_pixels <= blk_pixels;
    end
  end

  assign blk_ready  = (r_state == IDLE);
  assign mem_valid  = (r_state == DATA);
  assign mem_addr   = {r_idx, r_beat};
  assign mem_data   = w_data;
  assign mem_last   = (r_state == DATA) && w_is_last;
  assign meta_valid = (r_state == META);
  assign meta_idx   = r_idx;
  assign meta_comp  = r_comp;

  dcc_sat_counter #(.WIDTH(STAT_BITS)) u_stat_blocks (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_meta_done),
    .o_count (stat_blocks)
  );

  dcc_sat_counter #(.WIDTH(STAT_BITS)) u_stat_comp (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_meta_done && r_comp),
    .o_count (stat_comp)
  );

endmodule
